instr_controller: RTL
=====================

// Module: instr_controller
// PURPOSE
//  Upstream control stage for the datapath block. Holds a 16-bit instruction register (IR),
//  decodes it, and runs a Moore FSM that sequences the datapath. The FSM drives the
//  datapath's asel/bsel/vsel/shift/load*/write/readnum/writenum/ALUop/sximm8 inputs over
//  multiple cycles per instruction. Start/idle handshake is s/w.
// PARAMETERS
//  IR_RESET  16'h0000  IR value after reset.
// PORTS
//  clk       in   1   sole clock, rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  in        in   16  instruction word
//  load      in   1   capture in into IR (honoured only in WAIT)
//  s         in   1   start execution of IR (honoured only in WAIT)
//  w         out  1   1 = idle in WAIT, ready for load/s
//  asel      out  1   datapath A-mux select (1 = zero)
//  bsel      out  1   datapath B-mux select (1 = sximm5)
//  vsel      out  2   writeback select (00 mdata, 01 sximm8, 10 PC, 11 C)
//  shift     out  2   shifter op for B operand
//  ALUop     out  2   00 add, 01 sub, 10 and, 11 not B
//  loada     out  1   load A register
//  loadb     out  1   load B register
//  loadc     out  1   load C register
//  loads     out  1   load status register
//  write     out  1   register-file write enable
//  readnum   out  3   register-file read index
//  writenum  out  3   register-file write index
//  sximm8    out  8   IR[7:8-bit immediate], i.e. IR[7:0]; datapath sign-extends
//  sximm5    out  16  sign-extended IR[4:0]
// BEHAVIOUR
//  IR fields: opcode=IR[15:13] op=IR[12:11] Rn=IR[10:8] Rd=IR[7:5] sh=IR[4:3] Rm=IR[2:0].
//  Decode: 110/10 MOV Rn,#imm8. 110/00 MOV Rd,sh(Rm). 101/00 ADD Rd=Rn+sh(Rm).
//   101/01 CMP status=Rn-sh(Rm). 101/10 AND Rd=Rn&sh(Rm). 101/11 MVN Rd=~sh(Rm).
//   All other opcode/op combinations are illegal.
//  IR: loads in on a rising clk edge when load=1 and state=WAIT; otherwise holds.
//  States (Moore outputs; any output not listed is 0 in that state, and readnum/writenum are 0):
//   WAIT: w=1. If s=1, next state is DECODE; otherwise stay.
//   DECODE: MOV imm goes to WRITE_IMM. MOV reg and MVN go to GET_B. ADD/CMP/AND go to GET_A.
//    Illegal goes to WAIT.
//   GET_A: readnum=Rn, loada=1. Next state GET_B.
//   GET_B: readnum=Rm, loadb=1. Next state ALU.
//   ALU: shift=sh, bsel=0, ALUop from op (MOV reg uses 00), asel=1 for MOV reg/MVN and 0
//    otherwise, loadc=1, loads=1 only for CMP. CMP goes to WAIT; else WRITE_REG.
//   WRITE_REG: vsel=11, write=1, writenum=Rd. Next state WAIT.
//   WRITE_IMM: vsel=01, write=1, writenum=Rn. Next state WAIT.
//  Continuous outputs: sximm8=IR[7:0] and sximm5={{11{IR[4]}},IR[4:0]}, independent of state.
//  Latency, counted in edges from the s edge to w=1:
//   MOV imm = 3. MOV reg/MVN = 5. CMP = 5. ADD/AND = 6.
//  Simultaneous load and s in WAIT: IR takes the new word, and DECODE uses the new IR.
//  load or s while not in WAIT: ignored and not queued. The IR is never corrupted mid-instruction.
//  Reset, including mid-instruction: state goes to WAIT and IR to IR_RESET immediately
//   (async). All outputs take WAIT values (w=1, all others 0, sximm fields from IR_RESET).
//  No write or load strobe is asserted for more than one cycle per instruction step.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined:
//   - Adds output illegal (1 bit, reset 0) and a HALT state.
//   - An illegal decode goes DECODE to HALT: illegal=1, w=0, all strobes 0.
//   - HALT ignores s and load and leaves only via rst_n.
//  Undefined: no illegal port and no HALT state. An illegal decode returns silently to WAIT.
// TESTING
//  1 Reset: rst_n=0 mid-GET_B -> next sample has w=1, loadb=0, IR=IR_RESET; s during reset ignored.
//  2 MOV R0,#-5:
//    - Stimulus: in=16'hD0FB, load=1 and s=1 in the same cycle.
//    - Response: DECODE, then WRITE_IMM with vsel=01, write=1, writenum=0, sximm8=8'hFB;
//      w=1 on the 3rd edge.
//  3 ADD R2,R1,R0 LSL1: in=16'hA148.
//    - GET_A: readnum=1, loada=1. GET_B: readnum=0, loadb=1.
//    - ALU: shift=01, ALUop=00, asel=0, loadc=1.
//    - WRITE_REG: writenum=2, vsel=11, write=1. Then w=1.
//  4 CMP R1,R0: in=16'hA900.
//    - ALU state: ALUop=01, loads=1, loadc=1. No WRITE_REG cycle; write never 1.
//  5 MVN R3,R1: in=16'hB861.
//    - GET_A skipped. GET_B: readnum=1.
//    - ALU: ALUop=11, asel=1. WRITE_REG: writenum=3.
//  6 Busy guard: during ADD, pulse load with in=16'hD0FB and pulse s.
//    - IR stays 16'hA148 and the sequence completes unchanged.
//    - Illegal word 16'hE000: returns to WAIT (or HALT with illegal=1 under CTRL_ILLEGAL_TRAP_EN).

Source files
------------

// File: rtl/instr_controller_if.sv
// Instruction-controller bus: instruction/handshake from the host, control strobes to the datapath.
// CTRL_ILLEGAL_TRAP_EN adds the illegal flag to both modports.
interface instr_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [7:0]  sximm8;
  logic [15:0] sximm5;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal;

  modport master (
    output in, load, s,
    input  w, asel, bsel, vsel, shift, ALUop, loada, loadb, loadc, loads, write,
    input  readnum, writenum, sximm8, sximm5, illegal
  );
  modport slave (
    input  in, load, s,
    output w, asel, bsel, vsel, shift, ALUop, loada, loadb, loadc, loads, write,
    output readnum, writenum, sximm8, sximm5, illegal
  );
`else
  modport master (
    output in, load, s,
    input  w, asel, bsel, vsel, shift, ALUop, loada, loadb, loadc, loads, write,
    input  readnum, writenum, sximm8, sximm5
  );
  modport slave (
    input  in, load, s,
    output w, asel, bsel, vsel, shift, ALUop, loada, loadb, loadc, loads, write,
    output readnum, writenum, sximm8, sximm5
  );
`endif
endinterface

// File: rtl/instr_controller.sv
// Instruction register, decoder and Moore sequencer driving the datapath control inputs.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal decode traps in HALT with illegal=1).
module instr_controller #(
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_controller_if.slave bus
);

  localparam int unsigned IR_W  = 16;
  localparam int unsigned SX5_W = 5;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_WRITE_IMM
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  typedef enum logic [2:0] {
    I_MOV_IMM,
    I_MOV_REG,
    I_ADD,
    I_CMP,
    I_AND,
    I_MVN,
    I_ILLEGAL
  } instr_t;

  typedef struct packed {
    logic       w;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic [2:0] readnum;
    logic [2:0] writenum;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{w: 1'b1, default: '0};

  state_t          state_q, state_next;
  logic [IR_W-1:0] ir_q, ir_next;
  ctrl_t           ctrl_q, ctrl_next;
  instr_t          instr;

  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  function automatic instr_t decode(input logic [IR_W-1:0] ir);
    case (ir[15:11])
      5'b11010: return I_MOV_IMM;
      5'b11000: return I_MOV_REG;
      5'b10100: return I_ADD;
      5'b10101: return I_CMP;
      5'b10110: return I_AND;
      5'b10111: return I_MVN;
      default:  return I_ILLEGAL;
    endcase
  endfunction

  assign instr = decode(ir_q);
  assign op    = ir_q[12:11];
  assign rn    = ir_q[10:8];
  assign rd    = ir_q[7:5];
  assign sh    = ir_q[4:3];
  assign rm    = ir_q[2:0];

  // State, IR and registered control outputs; outputs follow the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= IR_RESET;
      ctrl_q  <= CTRL_RESET;
    end else begin
      state_q <= state_next;
      ir_q    <= ir_next;
      ctrl_q  <= ctrl_next;
    end
  end

  // Next state; IR only accepts a new word while idle so a running instruction is never disturbed.
  always_comb begin
    state_next = state_q;
    ir_next    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (bus.load) ir_next = bus.in;
        if (bus.s)    state_next = S_DECODE;
      end
      S_DECODE: begin
        case (instr)
          I_MOV_IMM:             state_next = S_WRITE_IMM;
          I_MOV_REG, I_MVN:      state_next = S_GET_B;
          I_ADD, I_CMP, I_AND:   state_next = S_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:               state_next = S_HALT;
`else
          default:               state_next = S_WAIT;
`endif
        endcase
      end
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_ALU;
      S_ALU:       state_next = (instr == I_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_next = S_WAIT;
      S_WRITE_IMM: state_next = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:      state_next = S_HALT;
`endif
      default:     state_next = S_WAIT;
    endcase
  end

  // Moore outputs of the upcoming state; IR fields are stable whenever they are consumed.
  always_comb begin
    ctrl_next = '0;
    case (state_next)
      S_WAIT: ctrl_next.w = 1'b1;
      S_GET_A: begin
        ctrl_next.readnum = rn;
        ctrl_next.loada   = 1'b1;
      end
      S_GET_B: begin
        ctrl_next.readnum = rm;
        ctrl_next.loadb   = 1'b1;
      end
      S_ALU: begin
        ctrl_next.shift  = sh;
        ctrl_next.alu_op = (instr == I_MOV_REG) ? 2'b00 : op;
        ctrl_next.asel   = (instr == I_MOV_REG) || (instr == I_MVN);
        ctrl_next.loadc  = 1'b1;
        ctrl_next.loads  = (instr == I_CMP);
      end
      S_WRITE_REG: begin
        ctrl_next.vsel     = 2'b11;
        ctrl_next.write    = 1'b1;
        ctrl_next.writenum = rd;
      end
      S_WRITE_IMM: begin
        ctrl_next.vsel     = 2'b01;
        ctrl_next.write    = 1'b1;
        ctrl_next.writenum = rn;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: ctrl_next.illegal = 1'b1;
`endif
      default: ctrl_next = '0;
    endcase
  end

  assign bus.w        = ctrl_q.w;
  assign bus.asel     = ctrl_q.asel;
  assign bus.bsel     = ctrl_q.bsel;
  assign bus.vsel     = ctrl_q.vsel;
  assign bus.shift    = ctrl_q.shift;
  assign bus.ALUop    = ctrl_q.alu_op;
  assign bus.loada    = ctrl_q.loada;
  assign bus.loadb    = ctrl_q.loadb;
  assign bus.loadc    = ctrl_q.loadc;
  assign bus.loads    = ctrl_q.loads;
  assign bus.write    = ctrl_q.write;
  assign bus.readnum  = ctrl_q.readnum;
  assign bus.writenum = ctrl_q.writenum;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal  = ctrl_q.illegal;
`endif

  assign bus.sximm8 = ir_q[7:0];
  assign bus.sximm5 = {{(IR_W-SX5_W){ir_q[SX5_W-1]}}, ir_q[SX5_W-1:0]};

endmodule
